// File: rtl/spi_frame_if.sv
// Bus bundle between the SPI frame master and its pixel buffer / SPI pins.
// The master modport is the controller's view; slave is the buffer/pin side.
interface spi_frame_if #(
    parameter int W  = 48,
    parameter int RW = 3,
    parameter int CW = 5
);
    logic          start;
    logic          abort;
    logic [RW-1:0] rrow;
    logic [CW-1:0] rcol;
    logic [W-1:0]  rdata;
    logic          sclk;
    logic          ss;
    logic          mosi;
    logic          busy;
    logic          done;

    modport master (
        input  start, abort, rdata,
        output rrow, rcol, sclk, ss, mosi, busy, done
    );

    modport slave (
        output start, abort, rdata,
        input  rrow, rcol, sclk, ss, mosi, busy, done
    );
endinterface

// File: rtl/spi_frame_master.sv
// Streams a rows x columns pixel frame out of a synchronous buffer as SPI mode 0,
// one W-bit word per address, MSB first, with ss held low across the whole frame.
//
//   state  | meaning
//   IDLE   | ss high, waiting for start; done pulses here after a clean frame
//   FETCH  | address presented to the pixel buffer
//   LOAD   | buffer word captured into the shift register
//   SHIFT  | W bit periods, each half low then half high
//   FINISH | ss held low for half cycles before release
module spi_frame_master #(
    parameter int segments = 2,
    parameter int rows     = 8,
    parameter int columns  = 32,
    parameter int bitdepth = 8,
    parameter int half     = 2,
    localparam int W  = bitdepth * 3 * segments,
    localparam int RW = (rows > 1) ? $clog2(rows) : 1,
    localparam int CW = (columns > 1) ? $clog2(columns) : 1,
    localparam int BW = (W > 1) ? $clog2(W) : 1,
    localparam int HW = (half > 1) ? $clog2(half) : 1
) (
    input  logic        clk,
    input  logic        rst,
    spi_frame_if.master bus
);

    if (half < 1) begin : g_bad_half
        $error("spi_frame_master: half must be at least 1");
    end

    typedef enum logic [2:0] {IDLE, FETCH, LOAD, SHIFT, FINISH} state_t;

    state_t        state_q, state_d;
    logic [HW-1:0] cnt_q, cnt_d;
    logic          phase_q, phase_d;
    logic [BW-1:0] bit_q, bit_d;
    logic [W-1:0]  shift_q, shift_d;
    logic [RW-1:0] rrow_q, rrow_d;
    logic [CW-1:0] rcol_q, rcol_d;
    logic          done_q, done_d;

    logic last_word;
    logic cnt_tc;
    logic last_col;

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state_q <= IDLE;
            cnt_q   <= '0;
            phase_q <= 1'b0;
            bit_q   <= '0;
            shift_q <= '0;
            rrow_q  <= '0;
            rcol_q  <= '0;
            done_q  <= 1'b0;
        end else begin
            state_q <= state_d;
            cnt_q   <= cnt_d;
            phase_q <= phase_d;
            bit_q   <= bit_d;
            shift_q <= shift_d;
            rrow_q  <= rrow_d;
            rcol_q  <= rcol_d;
            done_q  <= done_d;
        end
    end

    assign last_col  = (rcol_q == CW'(columns - 1));
    assign last_word = last_col && (rrow_q == RW'(rows - 1));
    assign cnt_tc    = (cnt_q == '0);

    always_comb begin
        state_d = state_q;
        cnt_d   = cnt_q;
        phase_d = phase_q;
        bit_d   = bit_q;
        shift_d = shift_q;
        rrow_d  = rrow_q;
        rcol_d  = rcol_q;
        done_d  = 1'b0;

        unique case (state_q)
            IDLE: begin
                if (bus.start && !bus.abort) begin
                    state_d = FETCH;
                    rrow_d  = '0;
                    rcol_d  = '0;
                end
            end
            FETCH: state_d = LOAD;
            LOAD: begin
                shift_d = bus.rdata;
                bit_d   = '0;
                phase_d = 1'b0;
                cnt_d   = HW'(half - 1);
                state_d = SHIFT;
            end
            SHIFT: begin
                if (!cnt_tc) begin
                    cnt_d = cnt_q - 1'b1;
                end else begin
                    cnt_d = HW'(half - 1);
                    if (!phase_q) begin
                        phase_d = 1'b1;
                    end else if (bit_q == BW'(W - 1)) begin
                        // word ends; FINISH reuses the reloaded counter as its ss hold
                        phase_d = 1'b0;
                        if (last_word) begin
                            state_d = FINISH;
                        end else begin
                            state_d = FETCH;
                            if (last_col) begin
                                rcol_d = '0;
                                rrow_d = rrow_q + 1'b1;
                            end else begin
                                rcol_d = rcol_q + 1'b1;
                            end
                        end
                    end else begin
                        phase_d = 1'b0;
                        bit_d   = bit_q + 1'b1;
                        shift_d = {shift_q[W-2:0], 1'b0};
                    end
                end
            end
            FINISH: begin
                if (!cnt_tc) begin
                    cnt_d = cnt_q - 1'b1;
                end else begin
                    state_d = IDLE;
                    done_d  = 1'b1;
                end
            end
            default: state_d = IDLE;
        endcase

        if (bus.abort && state_q != IDLE) begin
            state_d = IDLE;
            done_d  = 1'b0;
            cnt_d   = '0;
            phase_d = 1'b0;
            bit_d   = '0;
            shift_d = '0;
            rrow_d  = '0;
            rcol_d  = '0;
        end
    end

    assign bus.ss   = (state_q == IDLE);
    assign bus.sclk = (state_q == SHIFT) && phase_q;
    assign bus.busy = (state_q != IDLE);
    assign bus.done = done_q;
    assign bus.rrow = rrow_q;
    assign bus.rcol = rcol_q;

    always_comb begin
        bus.mosi = 1'b0;
        if (state_q == LOAD)       bus.mosi = bus.rdata[W-1];
        else if (state_q == SHIFT) bus.mosi = shift_q[W-1];
    end

endmodule

// File: tb/tb_spi_frame_master.sv
// Directed bench: default 8x32 frame (dut_a) and a tiny 1x2, half=1 frame (dut_b).
`timescale 1ns/1ps
module tb_spi_frame_master;
    logic clk   = 1'b0;
    logic rst_n = 1'b0;
    int   n_cmp = 0;
    int   n_bad = 0;

    always #5 clk = ~clk;

    spi_frame_if #(.W(48), .RW(3), .CW(5)) ifa ();
    spi_frame_if #(.W(48), .RW(1), .CW(1)) ifb ();

    spi_frame_master #(.segments(2), .rows(8), .columns(32), .bitdepth(8), .half(2))
        dut_a (.clk(clk), .rst(rst_n), .bus(ifa));
    spi_frame_master #(.segments(2), .rows(1), .columns(2), .bitdepth(8), .half(1))
        dut_b (.clk(clk), .rst(rst_n), .bus(ifb));

    function automatic logic [47:0] pix(int r, int c);
        if (r == 0 && c == 0) return 48'hA5_0000_0000_01;
        return {8'h3C, 8'(r), 8'(c), 8'(r * 7 + c), 8'hC3 ^ 8'(c), 8'(r + c + 1)};
    endfunction

    always @(posedge clk) begin
        ifa.rdata <= pix(int'(ifa.rrow), int'(ifa.rcol));
        ifb.rdata <= pix(int'(ifb.rrow), int'(ifb.rcol));
    end

    // Monitor A: counters only grow, per-frame indices restart when ss falls.
    int a_rises = 0, a_unstable = 0, a_ss_low = 0, a_done = 0, a_done_bad = 0;
    int a_word_err = 0, a_addr_err = 0, a_words = 0, a_wif = 0, a_bits = 0, a_addr_n = 0;
    logic [47:0] a_sr = '0, a_first = '0;
    logic a_prev_sclk = 1'b0, a_prev_ss = 1'b1, a_held = 1'b0;
    logic [2:0] a_lr = '0;
    logic [4:0] a_lc = '0;

    always @(negedge clk) begin
        if (!ifa.ss && a_prev_ss) begin a_wif = 0; a_bits = 0; a_addr_n = 0; end
        if (ifa.sclk) begin
            if (!a_prev_sclk) begin
                a_rises++; a_held = ifa.mosi; a_sr = {a_sr[46:0], ifa.mosi}; a_bits++;
                if (a_bits == 48) begin
                    a_bits = 0;
                    if (a_wif == 0) a_first = a_sr;
                    if (a_sr !== pix(a_wif / 32, a_wif % 32)) a_word_err++;
                    a_wif++; a_words++;
                end
            end else if (ifa.mosi !== a_held) a_unstable++;
        end
        if (!ifa.ss) begin
            a_ss_low++;
            if (a_prev_ss || {ifa.rrow, ifa.rcol} !== {a_lr, a_lc}) begin
                if (ifa.rrow !== 3'(a_addr_n / 32) || ifa.rcol !== 5'(a_addr_n % 32)) a_addr_err++;
                a_addr_n++; a_lr = ifa.rrow; a_lc = ifa.rcol;
            end
        end
        if (ifa.done) begin a_done++; if (!(ifa.ss && !a_prev_ss)) a_done_bad++; end
        a_prev_sclk = ifa.sclk; a_prev_ss = ifa.ss;
    end

    // Monitor B
    int b_rises = 0, b_unstable = 0, b_ss_low = 0, b_done = 0, b_words = 0, b_word_err = 0;
    int b_wif = 0, b_bits = 0, b_hi = 0, b_gap = -1;
    logic [47:0] b_sr = '0;
    logic b_prev_sclk = 1'b0, b_prev_ss = 1'b1, b_held = 1'b0;

    always @(negedge clk) begin
        if (ifb.ss) b_hi++;
        else begin
            if (b_prev_ss) begin
                if (b_done > 0) b_gap = b_hi;
                b_wif = 0; b_bits = 0;
            end
            b_hi = 0; b_ss_low++;
        end
        if (ifb.sclk) begin
            if (!b_prev_sclk) begin
                b_rises++; b_held = ifb.mosi; b_sr = {b_sr[46:0], ifb.mosi}; b_bits++;
                if (b_bits == 48) begin
                    b_bits = 0;
                    if (b_sr !== pix(0, b_wif)) b_word_err++;
                    b_wif++; b_words++;
                end
            end else if (ifb.mosi !== b_held) b_unstable++;
        end
        if (ifb.done) b_done++;
        b_prev_sclk = ifb.sclk; b_prev_ss = ifb.ss;
    end

    task automatic cyc(int n);
        repeat (n) begin @(posedge clk); #1; end
    endtask

    task automatic test_reset();
        #2;
        n_cmp++; if (ifa.ss !== 1'b1)   begin n_bad++; $display("FAIL rst_ss: got %b want 1", ifa.ss); end
        n_cmp++; if (ifa.sclk !== 1'b0) begin n_bad++; $display("FAIL rst_sclk: got %b want 0", ifa.sclk); end
        n_cmp++; if (ifa.mosi !== 1'b0) begin n_bad++; $display("FAIL rst_mosi: got %b want 0", ifa.mosi); end
        n_cmp++; if (ifa.busy !== 1'b0) begin n_bad++; $display("FAIL rst_busy: got %b want 0", ifa.busy); end
        n_cmp++; if (ifa.done !== 1'b0) begin n_bad++; $display("FAIL rst_done: got %b want 0", ifa.done); end
        n_cmp++; if ({ifa.rrow, ifa.rcol} !== 8'h00) begin n_bad++; $display("FAIL rst_addr: got %h want 00", {ifa.rrow, ifa.rcol}); end
        n_cmp++; if (ifb.ss !== 1'b1 || ifb.busy !== 1'b0) begin n_bad++; $display("FAIL rst_b: got ss=%b busy=%b want 1/0", ifb.ss, ifb.busy); end
        cyc(2); rst_n = 1'b1; cyc(2);
        n_cmp++; if (ifa.ss !== 1'b1 || ifa.busy !== 1'b0) begin n_bad++; $display("FAIL rst_release: got ss=%b busy=%b want 1/0", ifa.ss, ifa.busy); end
    endtask

    task automatic test_idle_priority();
        ifa.start = 1'b1; ifa.abort = 1'b1; cyc(1);
        n_cmp++; if (ifa.busy !== 1'b0 || ifa.ss !== 1'b1) begin n_bad++; $display("FAIL start_abort_idle: got busy=%b ss=%b want 0/1", ifa.busy, ifa.ss); end
        ifa.start = 1'b0; ifa.abort = 1'b0; cyc(2);
    endtask

    task automatic test_abort();
        int base, dbase, t;
        base = a_rises; dbase = a_done;
        ifa.start = 1'b1; cyc(1); ifa.start = 1'b0;
        n_cmp++; if (ifa.ss !== 1'b0) begin n_bad++; $display("FAIL start_ss: got %b want 0", ifa.ss); end
        t = 0;
        while (a_rises - base < 261 && t < 5000) begin cyc(1); t++; end
        n_cmp++; if (a_rises - base != 261) begin n_bad++; $display("FAIL abort_wait: got %0d rises want 261", a_rises - base); end
        ifa.abort = 1'b1; cyc(1); ifa.abort = 1'b0;
        n_cmp++; if ({ifa.ss, ifa.sclk, ifa.busy, ifa.mosi, ifa.done} !== 5'b10000) begin
            n_bad++; $display("FAIL abort_idle: got ss,sclk,busy,mosi,done=%b want 10000", {ifa.ss, ifa.sclk, ifa.busy, ifa.mosi, ifa.done}); end
        cyc(20);
        n_cmp++; if (a_done != dbase) begin n_bad++; $display("FAIL abort_no_done: got %0d pulses want 0", a_done - dbase); end
        ifa.start = 1'b1; cyc(1); ifa.start = 1'b0;
        n_cmp++; if (ifa.ss !== 1'b0 || {ifa.rrow, ifa.rcol} !== 8'h00) begin
            n_bad++; $display("FAIL restart_addr: got ss=%b addr=%h want 0/00", ifa.ss, {ifa.rrow, ifa.rcol}); end
        t = 0;
        while (a_wif < 1 && t < 500) begin cyc(1); t++; end
        n_cmp++; if (a_first !== 48'hA5_0000_0000_01) begin n_bad++; $display("FAIL restart_word0: got %h want a50000000001", a_first); end
    endtask

    task automatic test_rst_mid();
        int base, dbase, t;
        base = a_rises; dbase = a_done; t = 0;
        while (a_rises - base < 12 && t < 500) begin cyc(1); t++; end
        n_cmp++; if (ifa.busy !== 1'b1) begin n_bad++; $display("FAIL rst_mid_busy: got %b want 1", ifa.busy); end
        #2 rst_n = 1'b0; #1;
        n_cmp++; if ({ifa.ss, ifa.sclk, ifa.mosi, ifa.busy, ifa.done} !== 5'b10000) begin
            n_bad++; $display("FAIL rst_mid_async: got ss,sclk,mosi,busy,done=%b want 10000", {ifa.ss, ifa.sclk, ifa.mosi, ifa.busy, ifa.done}); end
        n_cmp++; if ({ifa.rrow, ifa.rcol} !== 8'h00) begin n_bad++; $display("FAIL rst_mid_addr: got %h want 00", {ifa.rrow, ifa.rcol}); end
        cyc(2); rst_n = 1'b1; cyc(10);
        n_cmp++; if (ifa.busy !== 1'b0 || a_done != dbase) begin
            n_bad++; $display("FAIL rst_mid_wait: got busy=%b done_pulses=%0d want 0/0", ifa.busy, a_done - dbase); end
    endtask

    task automatic test_full_frame();
        int r0, l0, d0, db0, we0, ae0, u0, w0, t;
        bit pulsed;
        r0 = a_rises; l0 = a_ss_low; d0 = a_done; db0 = a_done_bad;
        we0 = a_word_err; ae0 = a_addr_err; u0 = a_unstable; w0 = a_words;
        ifa.start = 1'b1; cyc(1); ifa.start = 1'b0;
        n_cmp++; if (ifa.ss !== 1'b0) begin n_bad++; $display("FAIL frame_ss_fall: got %b want 0", ifa.ss); end
        t = 0; pulsed = 1'b0;
        while (a_done == d0 && t < 60000) begin
            if (!pulsed && a_rises - r0 >= 1000) begin ifa.start = 1'b1; pulsed = 1'b1; end
            else ifa.start = 1'b0;
            cyc(1); t++;
        end
        ifa.start = 1'b0;
        cyc(3);
        n_cmp++; if (a_rises - r0 != 12288) begin n_bad++; $display("FAIL frame_rises: got %0d want 12288", a_rises - r0); end
        n_cmp++; if (a_ss_low - l0 != 49666) begin n_bad++; $display("FAIL frame_ss_low: got %0d want 49666", a_ss_low - l0); end
        n_cmp++; if (a_done - d0 != 1) begin n_bad++; $display("FAIL frame_done_count: got %0d want 1", a_done - d0); end
        n_cmp++; if (a_done_bad != db0) begin n_bad++; $display("FAIL frame_done_vs_ss: got %0d bad want 0", a_done_bad - db0); end
        n_cmp++; if (a_words - w0 != 256) begin n_bad++; $display("FAIL frame_words: got %0d want 256", a_words - w0); end
        n_cmp++; if (a_word_err != we0) begin n_bad++; $display("FAIL frame_word_data: got %0d bad words want 0", a_word_err - we0); end
        n_cmp++; if (a_addr_n != 256) begin n_bad++; $display("FAIL frame_addr_count: got %0d want 256", a_addr_n); end
        n_cmp++; if (a_addr_err != ae0) begin n_bad++; $display("FAIL frame_addr_order: got %0d bad want 0", a_addr_err - ae0); end
        n_cmp++; if (a_unstable != u0) begin n_bad++; $display("FAIL frame_mosi_stable: got %0d changes want 0", a_unstable - u0); end
        n_cmp++; if (a_first !== 48'hA5_0000_0000_01) begin n_bad++; $display("FAIL frame_word0: got %h want a50000000001", a_first); end
        n_cmp++; if (ifa.busy !== 1'b0 || ifa.ss !== 1'b1) begin n_bad++; $display("FAIL frame_end_idle: got busy=%b ss=%b want 0/1", ifa.busy, ifa.ss); end
    endtask

    task automatic test_back_to_back();
        int r0, l0, d0, w0, we0, u0, nd, t;
        r0 = b_rises; l0 = b_ss_low; d0 = b_done; w0 = b_words; we0 = b_word_err; u0 = b_unstable;
        nd = 0; t = 0;
        ifb.start = 1'b1;
        while (nd < 2 && t < 2000) begin
            cyc(1); t++;
            if (ifb.done === 1'b1) nd++;
        end
        ifb.start = 1'b0;
        cyc(5);
        n_cmp++; if (nd != 2) begin n_bad++; $display("FAIL b2b_wait: got %0d done pulses want 2", nd); end
        n_cmp++; if (b_rises - r0 != 192) begin n_bad++; $display("FAIL b2b_rises: got %0d want 192", b_rises - r0); end
        n_cmp++; if (b_done - d0 != 2) begin n_bad++; $display("FAIL b2b_done: got %0d want 2", b_done - d0); end
        n_cmp++; if (b_gap != 1) begin n_bad++; $display("FAIL b2b_ss_gap: got %0d want 1", b_gap); end
        n_cmp++; if (b_ss_low - l0 != 394) begin n_bad++; $display("FAIL b2b_ss_low: got %0d want 394", b_ss_low - l0); end
        n_cmp++; if (b_words - w0 != 4 || b_word_err != we0) begin
            n_bad++; $display("FAIL b2b_words: got %0d words %0d bad want 4/0", b_words - w0, b_word_err - we0); end
        n_cmp++; if (b_unstable != u0) begin n_bad++; $display("FAIL b2b_mosi_stable: got %0d want 0", b_unstable - u0); end
        n_cmp++; if (ifb.busy !== 1'b0) begin n_bad++; $display("FAIL b2b_stop: got busy=%b want 0", ifb.busy); end
    endtask

    initial begin
        ifa.start = 1'b0; ifa.abort = 1'b0;
        ifb.start = 1'b0; ifb.abort = 1'b0;
        test_reset();
        test_idle_priority();
        test_abort();
        test_rst_mid();
        test_full_frame();
        test_back_to_back();
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end
endmodule
